// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI-Stream beat types shared by the DMA-side buffering blocks.
package axi_pkg;

    typedef logic [255:0] data_256_t;
    typedef logic [31:0]  keep_32_t;

    typedef struct packed {
        data_256_t tdata;
        keep_32_t  tkeep;
        logic      tlast;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module axis_fifo_mem
    import axi_pkg::*;
#(
    parameter int WIDTH = $bits(axis_beat_t),
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI-Stream FIFO with tkeep/tlast, occupancy outputs and optional store-and-forward.
module axis_pkt_fifo
    import axi_pkg::*;
#(
    parameter int  DATA_WIDTH       = 256,
    parameter int  DEPTH            = 16,
    parameter int  PROG_FULL_THRESH = 12,
    parameter int  PACKET_MODE      = 0,
    parameter type data_t           = data_256_t
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  data_t                   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output data_t                   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    prog_full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PF_CNT   = CW'(PROG_FULL_THRESH);

    typedef struct packed {
        data_t                   tdata;
        logic [DATA_WIDTH/8-1:0] tkeep;
        logic                    tlast;
    } beat_t;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pkt_count;
    logic          r_release;
    logic          r_tready;

    beat_t         w_wr_beat;
    beat_t         w_rd_beat;
    logic          w_wr;
    logic          w_rd;
    logic          w_wr_last;
    logic          w_rd_last;
    logic          w_valid;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_pkt_nxt;

    assign w_wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

    axis_fifo_mem #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_beat),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_beat)
    );

    // Packet mode holds the head back until a whole packet is resident, unless the
    // FIFO filled without one (oversize packet), in which case it drains cut-through.
    assign w_valid = (r_count != '0) &&
                     ((PACKET_MODE == 0) || (r_pkt_count != '0) ||
                      (r_count == FULL_CNT) || r_release);

    assign w_wr      = s_axis_tvalid && r_tready;
    assign w_rd      = w_valid && m_axis_tready;
    assign w_wr_last = w_wr && s_axis_tlast;
    assign w_rd_last = w_rd && w_rd_beat.tlast;

    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
    assign w_pkt_nxt   = r_pkt_count + CW'(w_wr_last) - CW'(w_rd_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
            r_release   <= 1'b0;
            r_tready    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_pkt_count <= w_pkt_nxt;
            r_tready    <= (w_count_nxt != FULL_CNT);
            if (r_count == FULL_CNT && r_pkt_count == '0) begin
                r_release <= 1'b1;
            end else if (w_rd_last || r_count == '0) begin
                r_release <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_rd_beat.tdata;
    assign m_axis_tkeep  = w_rd_beat.tkeep;
    assign m_axis_tlast  = w_rd_beat.tlast;
    assign count         = r_count;
    assign pkt_count     = r_pkt_count;
    assign prog_full     = (r_count >= PF_CNT);
    assign empty         = (r_count == '0);

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - Stream-mode and packet-mode instances run side by side against a reference model.
module tb_axis_pkt_fifo;

    localparam int DEPTH = 16;
    localparam int NSTIM = 256;

    logic clk;
    logic rstn;
    logic m_tready;

    logic [1:0][255:0] s_tdata;
    logic [1:0][31:0]  s_tkeep;
    logic [1:0]        s_tlast;
    logic [1:0]        s_tvalid;
    logic [1:0]        s_tready;
    logic [1:0][255:0] m_tdata;
    logic [1:0][31:0]  m_tkeep;
    logic [1:0]        m_tlast;
    logic [1:0]        m_tvalid;
    logic [1:0][4:0]   cnt;
    logic [1:0][4:0]   pcnt;
    logic [1:0]        pfull;
    logic [1:0]        emp;

    // Stimulus beats in order; each FIFO's contents are stim[rd_i[k] .. wr_i[k]-1].
    logic [255:0] st_data [NSTIM];
    logic [31:0]  st_keep [NSTIM];
    logic         st_last [NSTIM];
    int           n_stim;
    int           wr_i [2];
    int           rd_i [2];
    bit           rel  [2];
    bit           send_en;

    int checks;
    int errors;

    axis_pkt_fifo #(
        .DATA_WIDTH(256), .DEPTH(DEPTH), .PROG_FULL_THRESH(12), .PACKET_MODE(0)
    ) u_stream (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tlast(s_tlast[0]),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
        .count(cnt[0]), .pkt_count(pcnt[0]), .prog_full(pfull[0]), .empty(emp[0])
    );

    axis_pkt_fifo #(
        .DATA_WIDTH(256), .DEPTH(DEPTH), .PROG_FULL_THRESH(12), .PACKET_MODE(1)
    ) u_pkt (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tlast(s_tlast[1]),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
        .count(cnt[1]), .pkt_count(pcnt[1]), .prog_full(pfull[1]), .empty(emp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic add_beat(input logic [255:0] d, input logic [31:0] kp, input bit l);
        st_data[n_stim] = d;
        st_keep[n_stim] = kp;
        st_last[n_stim] = l;
        n_stim++;
    endtask

    function automatic int m_size(input int k);
        return wr_i[k] - rd_i[k];
    endfunction

    function automatic int m_pkts(input int k);
        int n = 0;
        for (int i = rd_i[k]; i < wr_i[k]; i++) if (st_last[i]) n++;
        return n;
    endfunction

    function automatic bit m_valid(input int k);
        int sz = m_size(k);
        return (sz > 0) && (k == 0 || m_pkts(k) > 0 || sz == DEPTH || rel[k]);
    endfunction

    // One clock: drive, compare every output with the model, step the model over the edge.
    task automatic cycle();
        bit wr [2];
        bit rd [2];
        int sz [2];
        int pk [2];
        for (int k = 0; k < 2; k++) begin
            s_tvalid[k] = send_en && (wr_i[k] < n_stim);
            s_tdata[k]  = st_data[wr_i[k]];
            s_tkeep[k]  = st_keep[wr_i[k]];
            s_tlast[k]  = st_last[wr_i[k]];
            sz[k] = m_size(k);
            pk[k] = m_pkts(k);
            chk("count", k, cnt[k], sz[k]);
            chk("pkt_count", k, pcnt[k], pk[k]);
            chk("empty", k, emp[k], sz[k] == 0);
            chk("prog_full", k, pfull[k], sz[k] >= 12);
            chk("s_tready", k, s_tready[k], sz[k] < DEPTH);
            chk("m_tvalid", k, m_tvalid[k], m_valid(k));
            if (m_valid(k)) begin
                chk("m_tdata", k, m_tdata[k], st_data[rd_i[k]]);
                chk("m_tkeep", k, m_tkeep[k], st_keep[rd_i[k]]);
                chk("m_tlast", k, m_tlast[k], st_last[rd_i[k]]);
            end
            wr[k] = s_tvalid[k] && (sz[k] < DEPTH);
            rd[k] = m_valid(k) && m_tready;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (sz[k] == DEPTH && pk[k] == 0) rel[k] = 1'b1;
            else if ((rd[k] && st_last[rd_i[k]]) || sz[k] == 0) rel[k] = 1'b0;
            if (rd[k]) rd_i[k]++;
            if (wr[k]) wr_i[k]++;
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; n_stim = 0; send_en = 1'b0;
        for (int k = 0; k < 2; k++) begin wr_i[k] = 0; rd_i[k] = 0; rel[k] = 1'b0; end
        rstn = 1'b0; m_tready = 1'b0; s_tvalid = '0;
        s_tdata = '0; s_tkeep = '0; s_tlast = '0;

        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tready", k, s_tready[k], 0);
            chk("rst_tvalid", k, m_tvalid[k], 0);
            chk("rst_count", k, cnt[k], 0);
            chk("rst_pkt", k, pcnt[k], 0);
            chk("rst_pfull", k, pfull[k], 0);
            chk("rst_empty", k, emp[k], 1);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Fill 0..15 with the sink stalled, then drain.
        for (int i = 0; i < 16; i++) add_beat(256'(i), 32'hffff_ffff, 1'b0);
        send_en = 1'b1; m_tready = 1'b0;
        repeat (18) cycle();
        chk("fill_tready", 0, s_tready[0], 0);
        chk("fill_count", 0, cnt[0], 16);
        chk("fill_pfull", 0, pfull[0], 1);
        chk("oversize_valid", 1, m_tvalid[1], 1);
        m_tready = 1'b1;
        repeat (18) cycle();
        for (int k = 0; k < 2; k++) chk("drain_empty", k, emp[k], 1);

        // Concurrent throughput at occupancy 4.
        for (int i = 0; i < 104; i++) add_beat(rnd256(), $urandom(), 1'b1);
        m_tready = 1'b0;
        repeat (4) cycle();
        m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("thru_count", 0, cnt[0], 4);
            chk("thru_valid", 0, m_tvalid[0], 1);
            chk("thru_valid", 1, m_tvalid[1], 1);
            cycle();
        end
        repeat (6) cycle();
        for (int k = 0; k < 2; k++) chk("thru_empty", k, emp[k], 1);

        // 5-beat packet: held until tlast is stored.
        for (int i = 0; i < 5; i++) add_beat(rnd256(), $urandom(), i == 4);
        m_tready = 1'b0;
        repeat (4) cycle();
        chk("pkt_hold", 1, m_tvalid[1], 0);
        cycle();
        chk("pkt_release", 1, m_tvalid[1], 1);
        chk("pkt_cnt1", 1, pcnt[1], 1);
        m_tready = 1'b1;
        repeat (6) cycle();
        chk("pkt_cnt0", 1, pcnt[1], 0);

        // Oversize 20-beat packet.
        for (int i = 0; i < 20; i++) add_beat(rnd256(), $urandom(), i == 19);
        m_tready = 1'b0;
        repeat (18) cycle();
        chk("ovs_count", 1, cnt[1], 16);
        chk("ovs_pkt", 1, pcnt[1], 0);
        chk("ovs_valid", 1, m_tvalid[1], 1);
        m_tready = 1'b1;
        repeat (30) cycle();
        for (int k = 0; k < 2; k++) chk("ovs_empty", k, emp[k], 1);

        // Random tkeep/tlast and stalls across several pointer wraps.
        for (int i = 0; i < 40; i++) add_beat(rnd256(), $urandom(), (i == 39) || ($urandom_range(3) == 0));
        for (int i = 0; i < 150; i++) begin
            m_tready = ($urandom_range(3) != 0);
            send_en  = ($urandom_range(3) != 0);
            cycle();
        end
        m_tready = 1'b1; send_en = 1'b1;
        repeat (60) cycle();
        for (int k = 0; k < 2; k++) chk("wrap_empty", k, emp[k], 1);

        // Asynchronous reset with count=7, pkt_count=2.
        for (int i = 0; i < 8; i++) add_beat(rnd256(), $urandom(), (i == 1) || (i == 4));
        m_tready = 1'b0;
        repeat (7) cycle();
        for (int k = 0; k < 2; k++) begin
            chk("pre_rst_count", k, cnt[k], 7);
            chk("pre_rst_pkt", k, pcnt[k], 2);
        end
        send_en = 1'b0; s_tvalid = '0;
        #2 rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_count", k, cnt[k], 0);
            chk("arst_pkt", k, pcnt[k], 0);
            chk("arst_tvalid", k, m_tvalid[k], 0);
            chk("arst_empty", k, emp[k], 1);
            chk("arst_tready", k, s_tready[k], 0);
            wr_i[k] = n_stim; rd_i[k] = n_stim; rel[k] = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) add_beat(rnd256(), $urandom(), i == 2);
        send_en = 1'b1; m_tready = 1'b1;
        repeat (8) cycle();
        for (int k = 0; k < 2; k++) chk("resume_empty", k, emp[k], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
